// File: rtl/axis_exp_adc_emu.sv
`default_nettype none
// ============================================================================
// Module   : axis_exp_adc_emu
// Purpose  : SPI responder that stands in for the quad-SDI experiment ADC.
//            Conversion samples arrive on an AXI-Stream input and are played
//            out on NUM_SDI lanes. 24-clock register frames are captured and
//            forwarded on an AXI-Stream output. All SPI pins are
//            oversampled in the aclk domain.
// Ports    : aclk, aresetn (async, active low)
//            spi_csn, spi_sck, spi_mosi  - controller pins (synchronised)
//            spi_miso[NUM_SDI]           - lanes back to the controller
//            spi_resetn                  - low = synchronous functional reset
//            s_axis_*                    - conversion sample input
//            m_axis_*                    - {8'h00, 24-bit register frame}
//            underrun, frame_err         - single-cycle status pulses
// Options  : AXIS_EXP_ADC_EMU_READBACK_EN adds a 64x8 register file that
//            register writes update and register reads return on spi_miso[0].
// Revision : 1.0 - initial release
// ============================================================================
module axis_exp_adc_emu #(
  parameter int NUM_SDI     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  spi_csn,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic [NUM_SDI-1:0]    spi_miso,
  input  logic                  spi_resetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  underrun,
  output logic                  frame_err
);

  localparam int CNV_CLKS = DATA_WIDTH / NUM_SDI;
  localparam int MAX_CLKS = (CNV_CLKS > 24) ? CNV_CLKS : 24;
  localparam int CW       = $clog2(MAX_CLKS + 2);
  localparam logic [CW-1:0] C_CNV_N = CW'(CNV_CLKS);
  localparam logic [CW-1:0] C_REG_N = CW'(24);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  typedef enum logic {M_CONV, M_REG}    mode_t;

  // Synchroniser chain, bit order {csn, sck, mosi}
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] sync_d [SYNC_STAGES];
  logic       csn_prev_q, sck_prev_q;

  logic w_csn, w_sck, w_mosi;
  logic w_csn_fall, w_csn_rise, w_sck_rise, w_sck_fall;

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [23:0]           rsh_q, rsh_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic [DATA_WIDTH-1:0] csh_q, csh_d;
  logic [NUM_SDI-1:0]    miso_q, miso_d;
  logic [31:0]           mdata_q, mdata_d;
  logic                  mvalid_q, mvalid_d;
  logic                  underrun_q, underrun_d;
  logic                  ferr_q, ferr_d;
  logic                  tready_w;
  logic [DATA_WIDTH-1:0] w_next_sample;

`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
  logic [7:0] regfile_q [64];
  logic [7:0] rd_q, rd_d;
  logic [7:0] w_rd_byte;
  logic       w_wr_en;
`endif

  always_comb begin
    sync_d[0] = {spi_csn, spi_sck, spi_mosi};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b100;
      csn_prev_q <= 1'b1;
      sck_prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      csn_prev_q <= w_csn;
      sck_prev_q <= w_sck;
    end
  end

  assign w_csn      = sync_q[SYNC_STAGES-1][2];
  assign w_sck      = sync_q[SYNC_STAGES-1][1];
  assign w_mosi     = sync_q[SYNC_STAGES-1][0];
  assign w_csn_fall =  csn_prev_q & ~w_csn;
  assign w_csn_rise = ~csn_prev_q &  w_csn;
  assign w_sck_rise = ~sck_prev_q &  w_sck;
  assign w_sck_fall =  sck_prev_q & ~w_sck;

  // A fresh sample is taken only when one is offered; otherwise the last
  // one is replayed (and underrun flags it).
  assign w_next_sample = s_axis_tvalid ? s_axis_tdata : sample_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    rsh_d      = rsh_q;
    sample_d   = sample_q;
    csh_d      = csh_q;
    miso_d     = miso_q;
    mdata_d    = mdata_q;
    mvalid_d   = mvalid_q & ~m_axis_tready;
    underrun_d = 1'b0;
    ferr_d     = 1'b0;
    tready_w   = 1'b0;
`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
    rd_d      = rd_q;
    w_rd_byte = 8'h00;
    w_wr_en   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_csn_fall) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
          rd_d    = 8'h00;
`endif
          if (mode_q == M_CONV) begin
            tready_w   = s_axis_tvalid;
            underrun_d = ~s_axis_tvalid;
            sample_d   = w_next_sample;
            miso_d     = w_next_sample[DATA_WIDTH-1 -: NUM_SDI];
            // Group 0 goes out now; the shifter holds groups 1.. for SCK falls
            csh_d      = w_next_sample << NUM_SDI;
          end else begin
            miso_d = '0;
          end
        end
      end

      S_ACTIVE: begin
        if (w_csn_rise) begin
          state_d = S_IDLE;
          miso_d  = '0;
          if ((mode_q == M_CONV) && (cnt_q == C_CNV_N)) begin
            // complete conversion frame, nothing to report
          end else if (cnt_q == C_REG_N) begin
            mdata_d  = {8'h00, rsh_q};
            mvalid_d = 1'b1;
            // Overwriting an unconsumed word loses it; flag that.
            ferr_d   = mvalid_q & ~m_axis_tready;
            if ((mode_q == M_CONV) && (rsh_q[23:21] == 3'b101)) mode_d = M_REG;
            if ((mode_q == M_REG) && (rsh_q == 24'h801401))     mode_d = M_CONV;
`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
            w_wr_en = rsh_q[23];
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          if (w_sck_rise) begin
            if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
            rsh_d = {rsh_q[22:0], w_mosi};
          end
          if (w_sck_fall) begin
            if (mode_q == M_CONV) begin
              miso_d = csh_q[DATA_WIDTH-1 -: NUM_SDI];
              csh_d  = csh_q << NUM_SDI;
            end else begin
              miso_d = '0;
            end
`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
            // After 16 clocks rsh_q holds R[23:8]: bit 15 is R/W, [5:0] the address.
            if (cnt_q == CW'(16)) begin
              w_rd_byte = rsh_q[15] ? 8'h00 : regfile_q[rsh_q[5:0]];
              miso_d[0] = w_rd_byte[7];
              rd_d      = {w_rd_byte[6:0], 1'b0};
            end else if ((cnt_q > CW'(16)) && (cnt_q < CW'(24))) begin
              miso_d[0] = rd_q[7];
              rd_d      = {rd_q[6:0], 1'b0};
            end
`endif
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Controller-driven ADC reset: same end state as aresetn, but clocked.
    if (!spi_resetn) begin
      state_d    = S_IDLE;
      mode_d     = M_CONV;
      cnt_d      = '0;
      rsh_d      = '0;
      sample_d   = '0;
      csh_d      = '0;
      miso_d     = '0;
      mdata_d    = '0;
      mvalid_d   = 1'b0;
      underrun_d = 1'b0;
      ferr_d     = 1'b0;
      tready_w   = 1'b0;
`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
      rd_d       = 8'h00;
      w_wr_en    = 1'b0;
`endif
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      mode_q     <= M_CONV;
      cnt_q      <= '0;
      rsh_q      <= '0;
      sample_q   <= '0;
      csh_q      <= '0;
      miso_q     <= '0;
      mdata_q    <= '0;
      mvalid_q   <= 1'b0;
      underrun_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      rsh_q      <= rsh_d;
      sample_q   <= sample_d;
      csh_q      <= csh_d;
      miso_q     <= miso_d;
      mdata_q    <= mdata_d;
      mvalid_q   <= mvalid_d;
      underrun_q <= underrun_d;
      ferr_q     <= ferr_d;
    end
  end

`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_q <= 8'h00;
      for (int i = 0; i < 64; i++) regfile_q[i] <= 8'h00;
    end else begin
      rd_q <= rd_d;
      if (w_wr_en) regfile_q[rsh_q[13:8]] <= rsh_q[7:0];
    end
  end
`endif

  assign spi_miso      = miso_q;
  assign s_axis_tready = tready_w;
  assign m_axis_tdata  = mdata_q;
  assign m_axis_tvalid = mvalid_q;
  assign underrun      = underrun_q;
  assign frame_err     = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_exp_adc_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_exp_adc_emu
// Purpose  : Self-checking bench for axis_exp_adc_emu (NUM_SDI=4, 32-bit).
//            Acts as the SPI controller; expected lane values are queued
//            from a small behavioural model and popped as lanes are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_exp_adc_emu;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic [3:0]  spi_miso;
  logic        spi_resetn = 1'b1;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        underrun;
  logic        frame_err;

  axis_exp_adc_emu #(.NUM_SDI(4), .DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_resetn(spi_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .underrun(underrun), .frame_err(frame_err)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc = 0, n_und = 0, n_ferr = 0;

  // Scoreboards: lane values per sample point, and register words expected on m_axis
  logic [3:0]  lane_q[$];
  logic [31:0] mword_q[$];

  // Behavioural model state
  logic [31:0] model_sample = 32'h0;
  bit          model_reg = 1'b0;
  logic [7:0]  model_rf [64];

  always @(negedge aclk) begin
    if (s_axis_tready && s_axis_tvalid) n_acc++;
    if (underrun)  n_und++;
    if (frame_err) n_ferr++;
  end

  // Model of a frame start plus the lanes the controller should see at each
  // sample point (point i is after i SCK falls).
  task automatic model_frame(input int nclk, input logic [23:0] word);
    logic [3:0] v;
    if (!model_reg && s_axis_tvalid) model_sample = s_axis_tdata;
    for (int i = 0; i <= nclk; i++) begin
      v = 4'h0;
      if (!model_reg && i < 8) v = model_sample[31-4*i -: 4];
`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
      if (nclk == 24 && !word[23] && i >= 16 && i <= 23) v[0] = model_rf[word[13:8]][23-i];
`endif
      lane_q.push_back(v);
    end
    if (nclk == 24) begin
      mword_q.push_back({8'h00, word});
      if (!model_reg && word[23:21] == 3'b101) model_reg = 1'b1;
      else if (model_reg && word == 24'h801401) model_reg = 1'b0;
`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
      if (word[23]) model_rf[word[13:8]] = word[7:0];
`endif
    end
  endtask

  // Drive one SPI frame of nclk clocks; compare lanes against the scoreboard.
  task automatic spi_frame(input int nclk, input logic [23:0] word, input string name);
    logic [3:0] exp_v;
    spi_csn = 1'b0;
    repeat (4) @(negedge aclk);
    for (int i = 0; i <= nclk; i++) begin
      if (i < nclk) spi_mosi = word[nclk-1-i];
      repeat (2) @(negedge aclk);
      n_checks++;
      if (lane_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s lanes[%0d]: scoreboard empty, got %h", name, i, spi_miso);
      end else begin
        exp_v = lane_q.pop_front();
        if (spi_miso !== exp_v) begin
          n_fail++;
          $display("FAIL %s lanes[%0d]: got %h want %h", name, i, spi_miso, exp_v);
        end
      end
      if (i < nclk) begin
        spi_sck = 1'b1;
        repeat (4) @(negedge aclk);
        spi_sck = 1'b0;
        repeat (4) @(negedge aclk);
      end
    end
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    repeat (6) @(negedge aclk);
    n_checks++;
    if (spi_miso !== 4'h0) begin
      n_fail++;
      $display("FAIL %s idle lanes: got %h want 0", name, spi_miso);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({spi_miso, s_axis_tready, m_axis_tvalid, underrun, frame_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {spi_miso, s_axis_tready, m_axis_tvalid, underrun, frame_err});
    end
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    n_checks++;
    if ({spi_miso, s_axis_tready, m_axis_tvalid, underrun, frame_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got %b want 00000000",
               {spi_miso, s_axis_tready, m_axis_tvalid, underrun, frame_err});
    end
  endtask

  task automatic test_conv;
    int a0, u0;
    a0 = n_acc; u0 = n_und;
    s_axis_tdata = 32'h12345678; s_axis_tvalid = 1'b1;
    model_frame(8, 24'h0);
    spi_frame(8, 24'h0, "conv");
    s_axis_tvalid = 1'b0;
    n_checks++;
    if ((n_acc - a0) != 1 || (n_und - u0) != 0) begin
      n_fail++;
      $display("FAIL conv_handshake: accepts %0d underruns %0d want 1 0", n_acc - a0, n_und - u0);
    end
  endtask

  task automatic test_underrun;
    int a0, u0;
    a0 = n_acc; u0 = n_und;
    model_frame(8, 24'h0);
    spi_frame(8, 24'h0, "underrun");
    n_checks++;
    if ((n_acc - a0) != 0 || (n_und - u0) != 1) begin
      n_fail++;
      $display("FAIL underrun_pulse: accepts %0d underruns %0d want 0 1", n_acc - a0, n_und - u0);
    end
  endtask

  // Check the held m_axis word against the scoreboard; optionally accept it.
  task automatic check_mword(input string name, input bit accept);
    logic [31:0] exp_w;
    exp_w = (mword_q.size() != 0) ? mword_q[mword_q.size()-1] : 32'hxxxxxxxx;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_w) begin
      n_fail++;
      $display("FAIL %s m_axis: valid %b data %h want 1 %h", name, m_axis_tvalid, m_axis_tdata, exp_w);
    end
    if (accept) begin
      mword_q.delete();
      m_axis_tready = 1'b1;
      @(negedge aclk);
      m_axis_tready = 1'b0;
      @(negedge aclk);
      n_checks++;
      if (m_axis_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s m_accept: valid %b want 0", name, m_axis_tvalid);
      end
    end
  endtask

  task automatic test_reg_mode;
    int f0;
    f0 = n_ferr;
    model_frame(24, 24'hA00000);
    spi_frame(24, 24'hA00000, "enter_reg");
    check_mword("enter_reg", 1'b1);
    n_checks++;
    if (n_ferr != f0) begin
      n_fail++;
      $display("FAIL enter_reg_ferr: got %0d pulses want 0", n_ferr - f0);
    end
    model_frame(8, 24'h0);
    spi_frame(8, 24'h0, "reg_short");
    n_checks++;
    if ((n_ferr - f0) != 1 || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_short_ferr: pulses %0d valid %b want 1 0", n_ferr - f0, m_axis_tvalid);
    end
  endtask

  task automatic test_return_conv;
    int u0;
    model_frame(24, 24'h801401);
    spi_frame(24, 24'h801401, "exit_reg");
    check_mword("exit_reg", 1'b1);
    u0 = n_und;
    model_frame(8, 24'h0);
    spi_frame(8, 24'h0, "conv_again");
    n_checks++;
    if ((n_und - u0) != 1) begin
      n_fail++;
      $display("FAIL conv_again_underrun: got %0d want 1", n_und - u0);
    end
  endtask

  task automatic test_abort;
    int f0, a0;
    f0 = n_ferr;
    model_frame(5, 24'h0);
    spi_frame(5, 24'h0, "abort");
    n_checks++;
    if ((n_ferr - f0) != 1) begin
      n_fail++;
      $display("FAIL abort_ferr: got %0d want 1", n_ferr - f0);
    end
    a0 = n_acc;
    s_axis_tdata = 32'h9ABCDEF0; s_axis_tvalid = 1'b1;
    model_frame(8, 24'h0);
    spi_frame(8, 24'h0, "after_abort");
    s_axis_tvalid = 1'b0;
    n_checks++;
    if ((n_acc - a0) != 1 || (n_ferr - f0) != 1) begin
      n_fail++;
      $display("FAIL after_abort: accepts %0d ferr %0d want 1 1", n_acc - a0, n_ferr - f0);
    end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = n_ferr;
    model_frame(24, 24'h123456);
    spi_frame(24, 24'h123456, "bp_first");
    check_mword("bp_first", 1'b0);
    model_frame(24, 24'h234567);
    spi_frame(24, 24'h234567, "bp_second");
    check_mword("bp_second", 1'b1);
    n_checks++;
    if ((n_ferr - f0) != 1) begin
      n_fail++;
      $display("FAIL bp_overwrite_ferr: got %0d want 1", n_ferr - f0);
    end
  endtask

`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
  task automatic test_readback;
    model_frame(24, 24'h80055A);
    spi_frame(24, 24'h80055A, "rb_write");
    check_mword("rb_write", 1'b1);
    model_frame(24, 24'h000500);
    spi_frame(24, 24'h000500, "rb_read");
    check_mword("rb_read", 1'b1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) model_rf[i] = 8'h00;
    test_reset();
    test_conv();
    test_underrun();
    test_reg_mode();
    test_return_conv();
    test_abort();
    test_back_to_back();
`ifdef AXIS_EXP_ADC_EMU_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
